// File: rtl/timer_arbiter_pkg.sv
// Shared types, defaults and the round-robin winner search for timer_arbiter.
package timer_arbiter_pkg;

  localparam int DEF_N_REQ  = 4;
  localparam int DEF_MODULO = 128;
  localparam int MAX_REQ    = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_e;

  // First set bit above 'last' (wrapping within n requesters); returns 'last' if none.
  // Scanned downward so the closest candidate is the final assignment.
  function automatic int rr_pick(input logic [MAX_REQ-1:0] req, input int n, input int last);
    int idx;
    rr_pick = last;
    for (int i = MAX_REQ; i >= 1; i--) begin
      if (i <= n) begin
        idx = last + i;
        if (idx >= n) idx = idx - n;
        if (req[idx[4:0]]) rr_pick = idx;
      end
    end
  endfunction

endpackage

// File: rtl/timer_arbiter_if.sv
// Request/grant bundle between requesters and the shared interval timer.
interface timer_arbiter_if
  import timer_arbiter_pkg::*;
#(
  parameter int N_REQ  = DEF_N_REQ,
  parameter int MODULO = DEF_MODULO
);
  localparam int CW = $clog2(MODULO);
  localparam int IW = $clog2(N_REQ);

  logic [N_REQ-1:0] req;
  logic             pause;
  logic [N_REQ-1:0] grant;
  logic [IW-1:0]    grant_id;
  logic [N_REQ-1:0] done;
  logic             busy;
  logic [CW-1:0]    cnt;

  modport master (output req, pause, input grant, grant_id, done, busy, cnt);
  modport slave  (input req, pause, output grant, grant_id, done, busy, cnt);
endinterface

// File: rtl/timer_arbiter_counter.sv
// Modulo-MODULO up counter with carry; carry is combinational on the terminal count.
module Counter #(
  parameter int MODULO = 128,
  localparam int CW    = $clog2(MODULO)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic [CW-1:0] cnt,
  output logic          co
);

  assign co = en && (cnt == CW'(MODULO - 1));

  always_ff @(posedge clk) begin
    if (rst)     cnt <= '0;
    else if (en) cnt <= co ? '0 : cnt + 1'b1;
  end

endmodule

// File: rtl/timer_arbiter.sv
// Round-robin arbiter handing one shared interval counter to N_REQ requesters.
module timer_arbiter
  import timer_arbiter_pkg::*;
#(
  parameter int  N_REQ  = DEF_N_REQ,
  parameter int  MODULO = DEF_MODULO,
  localparam int CW     = $clog2(MODULO),
  localparam int IW     = $clog2(N_REQ)
) (
  input logic           clk,
  input logic           rst,
  timer_arbiter_if.slave bus
);

  state_e           state, state_n;
  logic [N_REQ-1:0] grant_q, grant_n, done_q, done_n;
  logic [IW-1:0]    gid_q, gid_n, last_q, last_n;
  logic [CW-1:0]    cnt;
  logic             en, co, cnt_rst;
  int               pick;

  // LOAD doubles as the counter clear so every interval starts from 0.
  assign en      = (state == RUN) && !bus.pause;
  assign cnt_rst = rst || (state == LOAD);

  Counter #(.MODULO(MODULO)) u_cnt (
    .clk (clk),
    .rst (cnt_rst),
    .en  (en),
    .cnt (cnt),
    .co  (co)
  );

  always_comb begin
    state_n = state;
    grant_n = grant_q;
    done_n  = '0;
    gid_n   = gid_q;
    last_n  = last_q;
    pick    = rr_pick(MAX_REQ'(bus.req), N_REQ, int'(last_q));
    case (state)
      IDLE: if (|bus.req) begin
        state_n       = LOAD;
        gid_n         = IW'(pick);
        grant_n       = '0;
        grant_n[gid_n] = 1'b1;
      end
      LOAD: if (!bus.req[gid_q]) begin
        state_n = IDLE;
        grant_n = '0;
        last_n  = gid_q;
      end else begin
        state_n = RUN;
      end
      RUN: if (co) begin
        // carry beats a simultaneous request drop
        state_n = IDLE;
        done_n  = grant_q;
        grant_n = '0;
        last_n  = gid_q;
      end else if (!bus.req[gid_q]) begin
        state_n = IDLE;
        grant_n = '0;
        last_n  = gid_q;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      grant_q <= '0;
      done_q  <= '0;
      gid_q   <= '0;
      last_q  <= IW'(N_REQ - 1);
    end else begin
      state   <= state_n;
      grant_q <= grant_n;
      done_q  <= done_n;
      gid_q   <= gid_n;
      last_q  <= last_n;
    end
  end

  assign bus.grant    = grant_q;
  assign bus.grant_id = gid_q;
  assign bus.done     = done_q;
  assign bus.busy     = (state != IDLE);
  assign bus.cnt      = cnt;

endmodule

// File: tb/tb_timer_arbiter.sv
// Directed bench for timer_arbiter with N_REQ=4, MODULO=8.
module tb_timer_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  timer_arbiter_if #(.N_REQ(4), .MODULO(8)) bif ();

  timer_arbiter #(.N_REQ(4), .MODULO(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    bif.req   = '0;
    bif.pause = 1'b0;

    // reset state
    tick(); tick();
    chk("rst_grant", bif.grant, 0);
    chk("rst_done", bif.done, 0);
    chk("rst_busy", bif.busy, 0);
    chk("rst_gid", bif.grant_id, 0);
    chk("rst_cnt", bif.cnt, 0);
    rst = 1'b0;

    // single requester full interval
    bif.req = 4'b0001;
    tick();
    chk("t1_load_grant", bif.grant, 4'b0001);
    chk("t1_load_busy", bif.busy, 1);
    chk("t1_load_gid", bif.grant_id, 0);
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("t1_cnt", bif.cnt, k);
      chk("t1_run_done", bif.done, 0);
    end
    bif.req = '0;
    tick();
    chk("t1_done", bif.done, 4'b0001);
    chk("t1_grant_off", bif.grant, 0);
    chk("t1_busy_off", bif.busy, 0);
    chk("t1_cnt_wrap", bif.cnt, 0);
    tick();
    chk("t1_done_pulse", bif.done, 0);
    chk("t1_cnt_hold", bif.cnt, 0);

    // all requesting: rotation with one idle/done cycle between grants
    do_reset();
    bif.req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      tick();
      chk("t2_grant", bif.grant, 32'(1 << (g % 4)));
      chk("t2_gid", bif.grant_id, g % 4);
      for (int k = 0; k < 8; k++) tick();
      chk("t2_last_cnt", bif.cnt, 7);
      if (g == 4) bif.req = '0;
      tick();
      chk("t2_done", bif.done, 32'(1 << (g % 4)));
      chk("t2_idle", bif.busy, 0);
    end

    // pause for 3 cycles at cnt=4; pause during LOAD is ignored
    do_reset();
    bif.req = 4'b0001;
    tick();
    bif.pause = 1'b1;
    tick();
    chk("t3_load_pause_cnt", bif.cnt, 0);
    chk("t3_load_pause_busy", bif.busy, 1);
    bif.pause = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    chk("t3_cnt4", bif.cnt, 4);
    bif.pause = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t3_paused_cnt", bif.cnt, 4);
    end
    bif.pause = 1'b0;
    tick(); tick(); tick();
    chk("t3_cnt7", bif.cnt, 7);
    chk("t3_no_early_done", bif.done, 0);
    bif.req = '0;
    tick();
    chk("t3_done", bif.done, 4'b0001);

    // abort by owner 1 at cnt=3, then requester 2 wins
    do_reset();
    bif.req = 4'b0110;
    tick();
    chk("t4_grant", bif.grant, 4'b0010);
    for (int k = 0; k < 4; k++) tick();
    chk("t4_cnt3", bif.cnt, 3);
    bif.req = 4'b0100;
    tick();
    chk("t4_abort_grant", bif.grant, 0);
    chk("t4_abort_busy", bif.busy, 0);
    chk("t4_abort_done", bif.done, 0);
    tick();
    chk("t4_next_grant", bif.grant, 4'b0100);
    bif.req = '0;
    tick();
    chk("t4_load_abort", bif.busy, 0);

    // reset mid-run
    do_reset();
    bif.req = 4'b0011;
    tick();
    for (int k = 0; k < 6; k++) tick();
    chk("t5_cnt5", bif.cnt, 5);
    rst = 1'b1;
    tick();
    chk("t5_rst_grant", bif.grant, 0);
    chk("t5_rst_cnt", bif.cnt, 0);
    chk("t5_rst_busy", bif.busy, 0);
    chk("t5_rst_done", bif.done, 0);
    rst = 1'b0;
    tick();
    chk("t5_regrant", bif.grant, 4'b0001);
    bif.req = '0;
    tick();

    // request drop coinciding with carry: done still pulses
    do_reset();
    bif.req = 4'b0100;
    tick();
    chk("t6_gid", bif.grant_id, 2);
    for (int k = 0; k < 8; k++) tick();
    chk("t6_cnt7", bif.cnt, 7);
    bif.req = '0;
    tick();
    chk("t6_done", bif.done, 4'b0100);
    chk("t6_grant_off", bif.grant, 0);
    tick();
    chk("t6_done_pulse", bif.done, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
